spi_master: RTL

//  Host-side SPI controller sitting directly upstream of the SPI memory: turns a parallel

---
 rtl/spi_master_if.sv | 21 ++
 rtl/spi_master.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/spi_master_if.sv
// Parallel request/response bus between a host and spi_master.
// The host drives the request side through the master modport; spi_master uses the slave modport.
interface spi_master_if;
    logic       start;
    logic       rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;

    modport master (
        output start, rw, addr, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  start, rw, addr, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/spi_master.sv
// SPI mode-0 master: one {addr[6:0], rw} command byte plus one data byte per frame, MSB first.
// Optional build macro SPI_MASTER_MISO_SYNC_EN adds a 2-flop synchronizer on miso_pin.
module spi_master #(
    parameter int CLK_DIV = 50,
    parameter int CS_IDLE = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    spi_master_if.slave bus,
    output logic        sclk_pin,
    output logic        cs_pin,
    output logic        mosi_pin,
    input  logic        miso_pin
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GW = (CS_IDLE > 1) ? $clog2(CS_IDLE) : 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        GAP
    } state_t;

    state_t        state_reg;
    logic [DW-1:0] div_cnt_reg;
    logic [GW-1:0] gap_cnt_reg;
    logic [3:0]    bit_cnt_reg;
    logic          phase_hi_reg;
    logic          rw_reg;
    logic [14:0]   frame_reg;
    logic [7:0]    shadow_reg;
    logic [7:0]    rdata_reg;
    logic          busy_reg;
    logic          done_reg;
    logic          sclk_reg;
    logic          cs_reg;
    logic          mosi_reg;
    logic          tick;

    assign tick      = (div_cnt_reg == DW'(CLK_DIV - 1));
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.rdata = rdata_reg;
    assign sclk_pin  = sclk_reg;
    assign cs_pin    = cs_reg;
    assign mosi_pin  = mosi_reg;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic [1:0] miso_sync_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miso_sync_reg <= 2'b00;
        end else begin
            miso_sync_reg <= {miso_sync_reg[0], miso_pin};
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            div_cnt_reg  <= '0;
            gap_cnt_reg  <= '0;
            bit_cnt_reg  <= 4'd0;
            phase_hi_reg <= 1'b0;
            rw_reg       <= 1'b0;
            frame_reg    <= '0;
            shadow_reg   <= 8'h00;
            rdata_reg    <= 8'h00;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            sclk_reg     <= 1'b0;
            cs_reg       <= 1'b1;
            mosi_reg     <= 1'b0;
        end else begin
            done_reg <= 1'b0;

            if (state_reg == IDLE) begin
                div_cnt_reg <= '0;
            end else if (tick) begin
                div_cnt_reg <= '0;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end

`ifdef SPI_MASTER_MISO_SYNC_EN
            // Synchronized miso reflects the sclk-rise sample two cycles later.
            if (state_reg == SHIFT && phase_hi_reg && rw_reg && bit_cnt_reg >= 4'd8 &&
                div_cnt_reg == DW'(1)) begin
                shadow_reg <= {shadow_reg[6:0], miso_sync_reg[1]};
            end
`endif

            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        // mosi carries addr[6] now; the remaining 15 bits wait in frame_reg.
                        frame_reg    <= {bus.addr[5:0], bus.rw, (bus.rw ? 8'h00 : bus.wdata)};
                        rw_reg       <= bus.rw;
                        shadow_reg   <= 8'h00;
                        bit_cnt_reg  <= 4'd0;
                        phase_hi_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                        cs_reg       <= 1'b0;
                        mosi_reg     <= bus.addr[6];
                        state_reg    <= SETUP;
                    end
                end

                SETUP: begin
                    if (tick) begin
                        sclk_reg     <= 1'b1;
                        phase_hi_reg <= 1'b1;
                        state_reg    <= SHIFT;
                    end
                end

                SHIFT: begin
                    if (tick) begin
                        if (phase_hi_reg) begin
                            sclk_reg     <= 1'b0;
                            phase_hi_reg <= 1'b0;
                            mosi_reg     <= frame_reg[14];
                            frame_reg    <= {frame_reg[13:0], 1'b0};
                        end else if (bit_cnt_reg == 4'd15) begin
                            state_reg <= HOLD;
                        end else begin
                            bit_cnt_reg  <= bit_cnt_reg + 4'd1;
                            sclk_reg     <= 1'b1;
                            phase_hi_reg <= 1'b1;
`ifndef SPI_MASTER_MISO_SYNC_EN
                            // Entering bits 8..15: sample miso on the same edge sclk rises.
                            if (rw_reg && bit_cnt_reg >= 4'd7) begin
                                shadow_reg <= {shadow_reg[6:0], miso_pin};
                            end
`endif
                        end
                    end
                end

                HOLD: begin
                    if (tick) begin
                        cs_reg      <= 1'b1;
                        mosi_reg    <= 1'b0;
                        done_reg    <= 1'b1;
                        gap_cnt_reg <= '0;
                        if (rw_reg) begin
                            rdata_reg <= shadow_reg;
                        end
                        state_reg <= GAP;
                    end
                end

                GAP: begin
                    if (tick) begin
                        if (gap_cnt_reg == GW'(CS_IDLE - 1)) begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 1'b1;
                        end
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule
